comp_serial_mag: RTL and testbench



---
 rtl/comp_serial_mag.sv | 149 ++++++++++++++
 tb/tb_comp_serial_mag.sv | 139 +++++++++++++
 2 files changed

// File: rtl/comp_serial_mag.sv
// comp_serial_mag -- bit-serial magnitude comparator with start/done handshake.
//
// Scans the two latched operands MSB-first, one bit per clock, and stops on
// the first differing bit (or after the LSB when the operands are equal).
// SIGNED=1 selects a two's-complement compare by swapping the sense of a
// difference found in the sign bit.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   start - request a compare; only looked at while idle
//   a, b  - operands, captured on the edge that accepts start
//   busy  - high while a compare is in progress (RUN or DONE)
//   done  - one-cycle pulse when the result becomes valid
//   aeb   - A == B
//   agb   - A > B
//   alb   - A < B
//   Results hold from the done cycle until the next start is accepted.
module comp_serial_mag #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             aeb,
   output logic             agb,
   output logic             alb
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] b_r, b_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             aeb_r, aeb_s;
   logic             agb_r, agb_s;
   logic             alb_r, alb_s;
   logic             ai_s, bi_s;

   // Current bit pair under examination.
   always_comb begin
      ai_s = a_r[cnt_r];
      bi_s = b_r[cnt_r];
   end

   // Next-state, datapath and output logic; every register holds by default.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      a_s     = a_r;
      b_s     = b_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      aeb_s   = aeb_r;
      agb_s   = agb_r;
      alb_s   = alb_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               a_s     = a;
               b_s     = b;
               cnt_s   = LAST;
               aeb_s   = 1'b0;
               agb_s   = 1'b0;
               alb_s   = 1'b0;
               busy_s  = 1'b1;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (ai_s != bi_s) begin
               // A set sign bit means the smaller value in two's complement.
               if ((SIGNED == 1'b1) && (cnt_r == LAST)) begin
                  agb_s = bi_s;
                  alb_s = ai_s;
               end else begin
                  agb_s = ai_s;
                  alb_s = bi_s;
               end
               done_s  = 1'b1;
               state_s = DONE;
            end else if (cnt_r == {CW{1'b0}}) begin
               aeb_s   = 1'b1;
               done_s  = 1'b1;
               state_s = DONE;
            end else begin
               cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         aeb_r   <= 1'b0;
         agb_r   <= 1'b0;
         alb_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         a_r     <= a_s;
         b_r     <= b_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         aeb_r   <= aeb_s;
         agb_r   <= agb_s;
         alb_r   <= alb_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign aeb  = aeb_r;
   assign agb  = agb_r;
   assign alb  = alb_r;

endmodule

// File: tb/tb_comp_serial_mag.sv
// tb_comp_serial_mag -- directed bench for comp_serial_mag.
// Three instances: 8-bit unsigned, 8-bit signed (sharing stimulus) and
// 16-bit signed. Inputs change and outputs are sampled on the falling edge.
module tb_comp_serial_mag;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;

   logic u_busy, u_done, u_aeb, u_agb, u_alb;
   logic s_busy, s_done, s_aeb, s_agb, s_alb;
   logic w_busy, w_done, w_aeb, w_agb, w_alb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   comp_serial_mag #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(u_busy), .done(u_done), .aeb(u_aeb), .agb(u_agb), .alb(u_alb));

   comp_serial_mag #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(s_busy), .done(s_done), .aeb(s_aeb), .agb(s_agb), .alb(s_alb));

   comp_serial_mag #(.WIDTH(16), .SIGNED(1'b1)) w_dut (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .busy(w_busy), .done(w_done), .aeb(w_aeb), .agb(w_agb), .alb(w_alb));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One compare on both 8-bit instances. ru/rs = {aeb,agb,alb} expected.
   // inject: drive a competing start while busy, which must be ignored.
   task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input int lat, input logic [2:0] ru, input logic [2:0] rs,
                       input bit inject);
      int first_u = 0, first_s = 0, dc_u = 0, dc_s = 0, bc_u = 0;
      @(negedge clk);
      start8 = 1'b1; a8 = av; b8 = bv;
      @(negedge clk);              // E0 has accepted the request
      start8 = 1'b0;
      chk({tag, "_clear_u"}, {29'd0, u_aeb, u_agb, u_alb}, 32'd0);
      chk({tag, "_clear_s"}, {29'd0, s_aeb, s_agb, s_alb}, 32'd0);
      for (int n = 1; n <= 12; n++) begin
         if (n > 1) @(negedge clk);
         if (inject && n == 1) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
         if (inject && n == 2) start8 = 1'b0;
         if (u_done) begin dc_u++; if (first_u == 0) first_u = n; end
         if (s_done) begin dc_s++; if (first_s == 0) first_s = n; end
         if (u_busy) bc_u++;
      end
      chk({tag, "_lat_u"}, first_u - 1, lat);
      chk({tag, "_lat_s"}, first_s - 1, lat);
      chk({tag, "_ndone_u"}, dc_u, 1);
      chk({tag, "_ndone_s"}, dc_s, 1);
      chk({tag, "_busy_u"}, bc_u, lat + 1);
      chk({tag, "_res_u"}, {29'd0, u_aeb, u_agb, u_alb}, {29'd0, ru});
      chk({tag, "_res_s"}, {29'd0, s_aeb, s_agb, s_alb}, {29'd0, rs});
   endtask

   // One compare on the 16-bit signed instance.
   task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int lat, input logic [2:0] r);
      int first = 0, dc = 0;
      @(negedge clk);
      start16 = 1'b1; a16 = av; b16 = bv;
      @(negedge clk);
      start16 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         if (w_done) begin dc++; if (first == 0) first = n; end
      end
      chk({tag, "_lat"}, first - 1, lat);
      chk({tag, "_ndone"}, dc, 1);
      chk({tag, "_res"}, {29'd0, w_aeb, w_agb, w_alb}, {29'd0, r});
   endtask

   initial begin
      int dc_u, dc_s;
      rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("reset_u", {27'd0, u_busy, u_done, u_aeb, u_agb, u_alb}, 32'd0);
      chk("reset_s", {27'd0, s_busy, s_done, s_aeb, s_agb, s_alb}, 32'd0);
      chk("reset_w", {27'd0, w_busy, w_done, w_aeb, w_agb, w_alb}, 32'd0);
      rst = 1'b0;

      // {aeb,agb,alb}: 3'b100 eq, 3'b010 gt, 3'b001 lt
      run8("a5_a4", 8'hA5, 8'hA4, 8, 3'b010, 3'b010, 1'b0);
      run8("80_7f", 8'h80, 8'h7F, 1, 3'b010, 3'b001, 1'b0);
      run8("3c_3c", 8'h3C, 8'h3C, 8, 3'b100, 3'b100, 1'b0);
      run8("00_01", 8'h00, 8'h01, 8, 3'b001, 3'b001, 1'b0);
      run8("10_20_inj", 8'h10, 8'h20, 3, 3'b001, 3'b001, 1'b1);
      run8("05_03", 8'h05, 8'h03, 6, 3'b010, 3'b010, 1'b0);
      run8("fe_01", 8'hFE, 8'h01, 1, 3'b010, 3'b001, 1'b0);

      // Reset in the middle of a compare: abandoned, no done pulse.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h00;
      @(negedge clk);              // after E0
      start8 = 1'b0;
      @(negedge clk);              // after E1
      @(negedge clk);              // after E2
      @(negedge clk);              // after E3
      rst = 1'b1;                  // sampled at E4
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_u", {27'd0, u_busy, u_done, u_aeb, u_agb, u_alb}, 32'd0);
      chk("midrst_s", {27'd0, s_busy, s_done, s_aeb, s_agb, s_alb}, 32'd0);
      dc_u = 0; dc_s = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (u_done) dc_u++;
         if (s_done) dc_s++;
      end
      chk("midrst_nodone_u", dc_u, 0);
      chk("midrst_nodone_s", dc_s, 0);
      run8("after_rst", 8'h01, 8'h00, 8, 3'b010, 3'b010, 1'b0);

      run16("ffff_0001", 16'hFFFF, 16'h0001, 1, 3'b001);
      run16("fffe_ffff", 16'hFFFE, 16'hFFFF, 16, 3'b001);
      run16("7fff_8000", 16'h7FFF, 16'h8000, 1, 3'b010);
      run16("1234_1234", 16'h1234, 16'h1234, 16, 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
